shift_unit_iter: RTL and testbench
==================================

# shift_unit_iter

Iterative, parametrised shift/rotate unit for the ALU datapath. It shifts a WIDTH-bit operand by a run-time amount of 0..WIDTH-1, moving at most STEP bit positions per clock. It supports logical, arithmetic and rotate modes and reports the last bit shifted out. Operands enter through a valid/ready handshake and results leave through one, so the ALU can stall the unit on backpressure.

## Interface
- WIDTH, 16: operand/result width; must be ≥ 2.
- STEP, 1: maximum bit positions shifted per cycle; 1 ≤ STEP ≤ WIDTH.
- AW, $clog2(WIDTH): shift-amount width (derived, not overridden).

- clk  in  1: single clock; all state changes on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: operand request.
- in_ready  out  1: unit can accept an operand; equals (state == IDLE).
- mode  in  3: 000 LSR, 001 LSL, 010 ASR, 011 ROR, 100 ROL; 101–111 illegal.
- a  in  WIDTH: operand.
- amt  in  AW: shift amount.
- out_valid  out  1: result present.
- out_ready  in  1: consumer accepts the result.
- Shift_out  out  WIDTH: result; 0 whenever out_valid = 0.
- carry_out  out  1: last bit shifted or rotated out; 0 when amt = 0 and whenever out_valid = 0.
- Shift_err  out  1: illegal mode; valid only with out_valid.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, accept (in_valid & in_ready at an edge):
  - Register a, mode and amt into data, mode_r and cnt; clear carry.
  - Illegal mode: go to DONE with data = a and Shift_err = 1. No shifting takes place.
  - amt = 0: go to DONE with data = a.
  - Otherwise: go to SHIFT.
- SHIFT, each edge:
  - k = min(STEP, cnt); data shifts by k per mode_r; cnt -= k.
  - carry = last bit vacated: LSR/ASR/ROR take data[k-1] before the shift; LSL/ROL take data[WIDTH-k].
  - When cnt becomes 0, go to DONE.
- Fill rules:
  - LSR and LSL fill with 0.
  - ASR fills with data[WIDTH-1].
  - ROR and ROL wrap around; no bit is lost.
- DONE:
  - out_valid = 1; Shift_out = data; carry_out = carry.
  - Outputs stay stable until the edge with out_ready = 1, then the FSM returns to IDLE.
- in_valid outside IDLE is ignored and is not queued.
- Reset value of every output: in_ready = 1; out_valid, Shift_out, carry_out and Shift_err = 0. The FSM resets to IDLE.
- Reset mid-operation aborts the operation immediately. The partial result is discarded and never presented.

## Timing
- Latency from the accept edge to out_valid is 1 + ceil(amt/STEP) cycles.
- Latency is 1 cycle when amt = 0 or mode is illegal.
- Worst case is 1 + ceil((WIDTH-1)/STEP) cycles.
- Throughput: one operation per (latency + 1) cycles when out_ready is held high. IDLE is re-entered for one cycle before the next accept.
- out_valid, Shift_out, carry_out and Shift_err are registered or decoded from state. No combinational path from any input to any output, except in_ready from state.
- Under backpressure (out_ready = 0), DONE holds indefinitely with all outputs frozen.

## Structure
- Shared package shift_pkg holds:
  - Mode encodings: MODE_LSR, MODE_LSL, MODE_ASR, MODE_ROR, MODE_ROL.
  - FSM state encoding: IDLE, SHIFT, DONE.
- Sub-module shift_step: a combinational one-pass shifter taking data, mode and k (0..STEP). It outputs the shifted data and the carry bit, and is instantiated once in the top.

## Test plan
- WIDTH = 16, STEP = 1, LSR, a = 0xB00F, amt = 4 → Shift_out = 0x0B00, carry_out = 1, out_valid exactly 5 cycles after the accept edge.
- WIDTH = 16, STEP = 4, ASR, a = 0x8001, amt = 15 → Shift_out = 0xFFFF, carry_out = 0, latency 5 cycles (steps of 4, 4, 4, 3).
- ROL, a = 0x8001, amt = 1 → Shift_out = 0x0003, carry_out = 1. LSL, a = 0x1234, amt = 0 → Shift_out = 0x1234, carry_out = 0, latency 1.
- mode = 3'b111, a = 0x5A5A → Shift_err = 1, Shift_out = 0x5A5A, latency 1. The next legal operation returns Shift_err = 0.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE → out_valid and outputs stable, in_ready = 0, in_valid pulses ignored. Raising out_ready gives one transfer, and in_ready = 1 on the next cycle.
- Assert rst for 1 cycle during SHIFT (LSR, a = 0xFFFF, amt = 8) → out_valid, Shift_out and carry_out = 0 and in_ready = 1 immediately. A following LSR, a = 0x00F0, amt = 4 returns 0x000F with carry_out = 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift/rotate unit.
// Holds the operation modes and the control FSM states.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_LSR = 3'b000,
    MODE_LSL = 3'b001,
    MODE_ASR = 3'b010,
    MODE_ROR = 3'b011,
    MODE_ROL = 3'b100
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic logic mode_is_legal(input logic [2:0] m);
    return m <= MODE_ROL;
  endfunction

endpackage

// File: rtl/shift_unit_iter_if.sv
// Operand/result handshake bundle for shift_unit_iter.
// The master side supplies operands and consumes results; the unit is the slave.
interface shift_unit_iter_if #(
  parameter int WIDTH = 16
);
  localparam int AW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       mode;
  logic [WIDTH-1:0] a;
  logic [AW-1:0]    amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Shift_out;
  logic             carry_out;
  logic             Shift_err;

  modport master (
    output in_valid, mode, a, amt, out_ready,
    input  in_ready, out_valid, Shift_out, carry_out, Shift_err
  );

  modport slave (
    input  in_valid, mode, a, amt, out_ready,
    output in_ready, out_valid, Shift_out, carry_out, Shift_err
  );
endinterface

// File: rtl/shift_step.sv
// Combinational one-pass shifter: moves i_data by i_k positions per i_mode
// and reports the last bit vacated (0 when i_k is 0).
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  input  mode_e            i_mode,
  input  logic [AW-1:0]    i_k,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry
);

  localparam int            AW1    = AW + 1;
  localparam logic [AW:0]   W_FULL = AW1'(WIDTH);

  logic [AW:0]       w_back;
  logic [AW-1:0]     w_km1;
  logic [WIDTH-1:0]  w_right;
  logic [WIDTH-1:0]  w_left;

  // Parking the last vacated bit at an edge avoids a variable bit-select.
  assign w_back  = W_FULL - {1'b0, i_k};
  assign w_km1   = i_k - AW'(1);
  assign w_right = i_data >> w_km1;
  assign w_left  = i_data << w_km1;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    o_data  = i_data;
    o_carry = 1'b0;
    case (i_mode)
      MODE_LSR: begin
        o_data  = i_data >> i_k;
        o_carry = w_right[0];
      end
      MODE_ASR: begin
        o_data  = $unsigned($signed(i_data) >>> i_k);
        o_carry = w_right[0];
      end
      MODE_ROR: begin
        o_data  = (i_data >> i_k) | (i_data << w_back);
        o_carry = w_right[0];
      end
      MODE_LSL: begin
        o_data  = i_data << i_k;
        o_carry = w_left[WIDTH-1];
      end
      MODE_ROL: begin
        o_data  = (i_data << i_k) | (i_data >> w_back);
        o_carry = w_left[WIDTH-1];
      end
      default: ;
    endcase
    if (i_k == '0) o_carry = 1'b0;
  end

endmodule

// File: rtl/shift_unit_iter.sv
// Iterative shift/rotate unit: shifts by up to STEP positions per clock,
// with valid/ready handshakes on both the operand and the result side.
module shift_unit_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  shift_unit_iter_if.slave bus
);

  localparam int          AW     = $clog2(WIDTH);
  localparam int          AW1    = AW + 1;
  localparam logic [AW:0] STEP_W = AW1'(STEP);

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  mode_e            r_mode;
  logic [AW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_err;

  logic [AW-1:0]    w_k;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_carry;
  logic             w_legal;
  logic             w_done;

  // k never exceeds the remaining count, so it always fits in AW bits.
  assign w_k     = ({1'b0, r_cnt} >= STEP_W) ? STEP_W[AW-1:0] : r_cnt;
  assign w_legal = mode_is_legal(bus.mode);

  shift_step #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_step (
    .i_data  (r_data),
    .i_mode  (r_mode),
    .i_k     (w_k),
    .o_data  (w_step_data),
    .o_carry (w_step_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_mode  <= MODE_LSR;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_data  <= bus.a;
            r_mode  <= w_legal ? mode_e'(bus.mode) : MODE_LSR;
            r_cnt   <= bus.amt;
            r_carry <= 1'b0;
            r_err   <= ~w_legal;
            r_state <= (!w_legal || bus.amt == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_data  <= w_step_data;
          r_carry <= w_step_carry;
          r_cnt   <= r_cnt - w_k;
          if (r_cnt == w_k) r_state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Result outputs are gated by state so nothing leaks while no result is held.
  assign w_done        = (r_state == DONE);
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = w_done;
  assign bus.Shift_out = w_done ? r_data : '0;
  assign bus.carry_out = w_done & r_carry;
  assign bus.Shift_err = w_done & r_err;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Self-checking bench: two units (STEP=1 and STEP=4) run identical operations
// and are compared against a whole-amount arithmetic model of each mode.
module tb_shift_unit_iter;
  import shift_pkg::*;

  localparam int WIDTH = 16;
  localparam int AW    = $clog2(WIDTH);
  localparam int MAXW  = 40;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_unit_iter_if #(.WIDTH(WIDTH)) bus1 ();
  shift_unit_iter_if #(.WIDTH(WIDTH)) bus4 ();

  shift_unit_iter #(.WIDTH(WIDTH), .STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  shift_unit_iter #(.WIDTH(WIDTH), .STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-amount reference: one arithmetic shift of the full amount.
  task automatic model(input logic [2:0] m, input logic [WIDTH-1:0] a, input int amt,
                       input int step, output logic [WIDTH-1:0] res, output logic cy,
                       output logic err, output int lat);
    int unsigned ua;
    int          sa;
    int unsigned full;
    ua   = a;
    sa   = $signed(a);
    full = (1 << WIDTH) - 1;
    err  = (m > 3'd4);
    res  = a;
    cy   = 1'b0;
    lat  = 1;
    if (!err && amt != 0) begin
      lat = 1 + (amt + step - 1) / step;
      case (m)
        3'd0: begin res = WIDTH'(ua / (1 << amt));                          cy = a[amt-1];       end
        3'd1: begin res = WIDTH'((ua * (1 << amt)) & full);                 cy = a[WIDTH-amt];   end
        3'd2: begin res = WIDTH'(sa >>> amt);                               cy = a[amt-1];       end
        3'd3: begin res = WIDTH'(((ua >> amt) | (ua << (WIDTH-amt))) & full); cy = a[amt-1];     end
        default: begin res = WIDTH'(((ua << amt) | (ua >> (WIDTH-amt))) & full); cy = a[WIDTH-amt]; end
      endcase
    end
  endtask

  task automatic drive_in(input logic v, input logic [2:0] m, input logic [WIDTH-1:0] a,
                          input logic [AW-1:0] amt);
    bus1.in_valid = v; bus1.mode = m; bus1.a = a; bus1.amt = amt;
    bus4.in_valid = v; bus4.mode = m; bus4.a = a; bus4.amt = amt;
  endtask

  task automatic scramble_in();
    drive_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             WIDTH'($urandom), AW'($urandom));
  endtask

  task automatic run_op(input string tag, input logic [2:0] m, input logic [WIDTH-1:0] a,
                        input logic [AW-1:0] amt, input int hold);
    logic [WIDTH-1:0] r1, r4;
    logic             c1, c4, e1, e4;
    int               l1, l4;
    int               got1, got4, cyc;
    logic             stable;
    logic [WIDTH+1:0] snap1, snap4;
    model(m, a, int'(amt), 1, r1, c1, e1, l1);
    model(m, a, int'(amt), 4, r4, c4, e4, l4);
    got1 = 0; got4 = 0; cyc = 0; stable = 1'b1;
    snap1 = '0; snap4 = '0;

    @(negedge clk);
    check($sformatf("%s in_ready", tag), 32'({bus1.in_ready, bus4.in_ready}), 32'h3);
    drive_in(1'b1, m, a, amt);

    while ((got1 == 0 || got4 == 0) && cyc < MAXW) begin
      @(negedge clk);
      cyc++;
      if (got1 == 0 && bus1.out_valid) begin
        got1  = cyc;
        snap1 = {bus1.Shift_err, bus1.carry_out, bus1.Shift_out};
      end else if (got1 != 0 && {bus1.Shift_err, bus1.carry_out, bus1.Shift_out} != snap1)
        stable = 1'b0;
      if (got4 == 0 && bus4.out_valid) begin
        got4  = cyc;
        snap4 = {bus4.Shift_err, bus4.carry_out, bus4.Shift_out};
      end else if (got4 != 0 && {bus4.Shift_err, bus4.carry_out, bus4.Shift_out} != snap4)
        stable = 1'b0;
      scramble_in();
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if ({bus1.Shift_err, bus1.carry_out, bus1.Shift_out} != snap1 || !bus1.out_valid)
        stable = 1'b0;
      if ({bus4.Shift_err, bus4.carry_out, bus4.Shift_out} != snap4 || !bus4.out_valid)
        stable = 1'b0;
      scramble_in();
    end

    check($sformatf("%s s1 latency", tag), 32'(got1), 32'(l1));
    check($sformatf("%s s4 latency", tag), 32'(got4), 32'(l4));
    check($sformatf("%s s1 result", tag), 32'({bus1.Shift_err, bus1.carry_out, bus1.Shift_out}),
          32'({e1, c1, r1}));
    check($sformatf("%s s4 result", tag), 32'({bus4.Shift_err, bus4.carry_out, bus4.Shift_out}),
          32'({e4, c4, r4}));
    check($sformatf("%s busy in_ready", tag), 32'({bus1.in_ready, bus4.in_ready}), 32'h0);
    check($sformatf("%s held stable", tag), 32'(stable), 32'h1);

    drive_in(1'b0, 3'd0, '0, '0);
    bus1.out_ready = 1'b1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    bus4.out_ready = 1'b0;
    check($sformatf("%s after transfer", tag),
          32'({bus1.out_valid, bus4.out_valid, bus1.in_ready, bus4.in_ready}), 32'h3);
  endtask

  initial begin
    logic [2:0] m;
    rst = 1'b1;
    drive_in(1'b0, 3'd0, '0, '0);
    bus1.out_ready = 1'b0;
    bus4.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset s1 outputs", 32'({bus1.in_ready, bus1.out_valid, bus1.carry_out, bus1.Shift_err,
          bus1.Shift_out}), 32'h1 << (WIDTH + 3));
    check("reset s4 outputs", 32'({bus4.in_ready, bus4.out_valid, bus4.carry_out, bus4.Shift_err,
          bus4.Shift_out}), 32'h1 << (WIDTH + 3));
    rst = 1'b0;

    run_op("lsr b00f/4",   3'd0, 16'hB00F, 4'd4,  0);
    run_op("asr 8001/15",  3'd2, 16'h8001, 4'd15, 0);
    run_op("rol 8001/1",   3'd4, 16'h8001, 4'd1,  0);
    run_op("lsl 1234/0",   3'd1, 16'h1234, 4'd0,  0);
    run_op("illegal 111",  3'd7, 16'h5A5A, 4'd3,  0);
    run_op("legal after",  3'd0, 16'h0F0F, 4'd3,  0);
    run_op("ror backpres", 3'd3, 16'h1357, 4'd5,  3);

    @(negedge clk);
    drive_in(1'b1, 3'd0, 16'hFFFF, 4'd8);
    @(negedge clk);
    drive_in(1'b0, 3'd0, '0, '0);
    rst = 1'b1;
    #1;
    check("mid reset s1", 32'({bus1.in_ready, bus1.out_valid, bus1.carry_out, bus1.Shift_out}),
          32'h1 << (WIDTH + 2));
    check("mid reset s4", 32'({bus4.in_ready, bus4.out_valid, bus4.carry_out, bus4.Shift_out}),
          32'h1 << (WIDTH + 2));
    @(negedge clk);
    rst = 1'b0;
    run_op("post reset",   3'd0, 16'h00F0, 4'd4,  0);

    for (int i = 0; i < 30; i++) begin
      m = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      run_op($sformatf("rand%0d", i), m, WIDTH'($urandom), AW'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
